fib_chuan_split: RTL and testbench
==================================

// Module: fib_chuan_split
// PURPOSE
//  Receive-side stage directly downstream of the Fibonacci-codeword concatenator.
//  Takes one 64-bit concatenated frame (F = packed codeword bits, S = end-of-codeword markers)
//  and splits it back into its right-aligned 32-bit Fibonacci codewords.
//  Codewords are emitted one at a time over a valid/ready handshake.
//  The frame is scanned LSB-first, one bit per cycle. Codeword k occupies F[end_k:start_k].
//  S[end_k] marks its MSB, which must be 1.
// PARAMETERS
//  W_IN      64  frame width of in_F / in_S
//  W_OUT     32  codeword width of out_f
//  MAX_WORDS 2   maximum codewords per frame
// PORTS
//  clk       in   1      clock, all state updates on rising edge
//  rst       in   1      asynchronous, active-low reset
//  en        in   1      frame strobe; in_F/in_S sampled when en=1 and busy=0
//  in_F      in   W_IN   concatenated codeword bits
//  in_S      in   W_IN   marker mask, bit set at MSB position of each codeword
//  out_f     out  W_OUT  extracted codeword, right-aligned, zero-extended
//  out_valid out  1      out_f holds a codeword
//  out_ready in   1      consumer accepts out_f when out_valid & out_ready
//  busy      out  1      frame in progress (SCAN/EMIT/FIN)
//  done      out  1      one-cycle pulse at end of frame
//  words     out  2      codewords emitted in current/last frame; valid with done
//  err       out  1      frame format error; sticky until next accepted en
// BEHAVIOUR
//  Reset: out_f=0, out_valid=0, busy=0, done=0, words=0, err=0, state=IDLE.
//  Reset mid-frame discards the frame with no done pulse.
//  FSM states: IDLE, SCAN, EMIT, FIN. Internal state:
//   - fr/sr: shift registers, W_IN bits
//   - acc: W_OUT bits
//   - len: 0..W_OUT
//   - wcnt
//  IDLE: busy=0.
//   - en=1: fr<=in_F, sr<=in_S, acc<=0, len<=0, words<=0, err<=0 -> SCAN.
//   - en while busy=1 is ignored.
//  SCAN, one cycle per frame bit:
//   - If sr==0 on entry: go to FIN. If fr!=0 at that point, set err (residual bits with no marker).
//   - Otherwise take b=fr[0], m=sr[0], then shift fr and sr right by 1.
//   - len<W_OUT: acc[len]<=b, len++. len==W_OUT: bit dropped, err<=1 (codeword >W_OUT bits).
//   - m=1: go to EMIT with out_f = acc including the current bit. If b=0, err<=1 (marker on a 0 MSB).
//  EMIT: out_valid=1, with out_f and words held stable until the handshake.
//   - On out_valid&out_ready: out_valid<=0, words++, acc<=0, len<=0.
//   - If words+1==MAX_WORDS: go to FIN. If sr!=0 at that point, err<=1 (excess markers).
//   - Otherwise go to SCAN.
//  FIN: done=1 for exactly one cycle, busy=1, then IDLE (busy=0 on the following cycle).
//  Latency from en accept:
//   - first out_valid: p+2 cycles, where p = bit index of the first marker (1 latch cycle + p+1 SCAN cycles).
//   - each later codeword: its own length in cycles after the previous handshake.
//  Empty frame (in_S=0, in_F=0): IDLE->SCAN->FIN. done 2 cycles after en, words=0, err=0, no out_valid.
//  A zero-length codeword cannot occur; a marker always closes a segment of length >=1.
//  Stall: out_ready low holds EMIT indefinitely. No bits are lost and scanning pauses.
//  Error conditions do not abort the frame. Scanning and emission continue; err only flags the frame.
// TESTING
//  - F=0x5B, S=0x48 (codewords 1011, 101), out_ready=1:
//    out_f=0x0000000B valid 5 cycles after en, then 0x00000005; done, words=2, err=0.
//  - Same frame, out_ready low 10 cycles in first EMIT:
//    out_f=0xB and valid held stable 10 cycles; then normal completion.
//  - F=0, S=0: done pulse 2 cycles after en; words=0, err=0, out_valid never asserted.
//  - F=0xFFFFFFFF, S=0x80000000:
//    out_f=0xFFFFFFFF after 33 cycles; words=1, err=0. With S=0x100000000 (33-bit segment): err=1.
//  - F=0x3, S=0x1: out_f=0x1 emitted, residual F bit1 -> err=1, words=1.
//    Then a clean frame clears err.
//  - rst low during SCAN of case 1: all outputs 0 immediately, no done.
//    A new frame after release decodes correctly.

Source files
------------

// File: rtl/fib_chuan_split.sv
// fib_chuan_split
//   Receive-side splitter for frames built by the Fibonacci-codeword
//   concatenator. A frame is a packed bit vector in_F with a companion
//   marker mask in_S; each set bit of in_S marks the MSB of one codeword.
//   The frame is scanned LSB-first, one bit per cycle. Each codeword is
//   presented right-aligned and zero-extended on out_f.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   en         frame strobe, sampled only while idle (busy=0)
//   in_F       concatenated codeword bits
//   in_S       end-of-codeword marker mask
//   out_f      extracted codeword (right-aligned)
//   out_valid  out_f holds a codeword
//   out_ready  consumer accepts out_f on out_valid & out_ready
//   busy       frame in progress
//   done       one-cycle pulse at end of frame
//   words      codewords emitted in the current/last frame
//   err        frame format error, sticky until the next accepted frame
//   state_dbg  current FSM state (IDLE=0, SCAN=1, EMIT=2, FIN=3)
//
// Handshake: out_f and words are held stable while out_valid=1 and
//   out_ready=0; a codeword is consumed on the rising edge where
//   out_valid and out_ready are both 1, and out_valid drops after it.
module fib_chuan_split #(
    parameter int W_IN      = 64,
    parameter int W_OUT     = 32,
    parameter int MAX_WORDS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [W_IN-1:0]   in_F,
    input  logic [W_IN-1:0]   in_S,
    output logic [W_OUT-1:0]  out_f,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [1:0]        words,
    output logic              err,
    output logic [1:0]        state_dbg
);

    localparam int LW = $clog2(W_OUT + 1);
    localparam int IW = $clog2(W_OUT);
    localparam logic [LW-1:0] LEN_MAX = LW'(W_OUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t            state;
    logic [W_IN-1:0]   fr;
    logic [W_IN-1:0]   sr;
    logic [W_OUT-1:0]  acc;
    logic [W_OUT-1:0]  acc_nx;
    logic [LW-1:0]     len;

    assign state_dbg = state;

    // Accumulator including the bit being scanned this cycle; once the
    // codeword already fills W_OUT bits the new bit is dropped.
    always_comb begin
        acc_nx = acc;
        if (len < LEN_MAX) begin
            acc_nx[len[IW-1:0]] = fr[0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            fr        <= '0;
            sr        <= '0;
            acc       <= '0;
            len       <= '0;
            out_f     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            words     <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        fr    <= in_F;
                        sr    <= in_S;
                        acc   <= '0;
                        len   <= '0;
                        words <= '0;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        state <= SCAN;
                    end
                end

                SCAN: begin
                    if (sr == '0) begin
                        // No marker left: any remaining data bits are orphaned.
                        if (fr != '0) begin
                            err <= 1'b1;
                        end
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        fr <= fr >> 1;
                        sr <= sr >> 1;
                        if (len < LEN_MAX) begin
                            acc <= acc_nx;
                            len <= len + LW'(1);
                        end else begin
                            err <= 1'b1;
                        end
                        if (sr[0]) begin
                            out_f     <= acc_nx;
                            out_valid <= 1'b1;
                            // A Fibonacci codeword's top bit is always 1.
                            if (!fr[0]) begin
                                err <= 1'b1;
                            end
                            state <= EMIT;
                        end
                    end
                end

                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        words     <= words + 2'd1;
                        acc       <= '0;
                        len       <= '0;
                        if (int'(words) + 1 == MAX_WORDS) begin
                            // Frame is full; any marker still pending is excess.
                            if (sr != '0) begin
                                err <= 1'b1;
                            end
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            state <= SCAN;
                        end
                    end
                end

                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fib_chuan_split.sv
// tb_fib_chuan_split
//   Directed and randomized frames for fib_chuan_split. Expected codewords,
//   per-codeword latencies, word count and error flag come from a
//   reference model that walks the marker positions of each frame.
//   Latency convention: the en-accept edge counts as edge 1, so the first
//   codeword (marker at bit p) is seen after edge p+2; later codewords are
//   seen <length> edges after the previous handshake edge.
module tb_fib_chuan_split;

    localparam int W_IN      = 64;
    localparam int W_OUT     = 32;
    localparam int MAX_WORDS = 2;
    localparam int BUDGET    = 300;

    logic              clk;
    logic              rst;
    logic              en;
    logic [W_IN-1:0]   in_F;
    logic [W_IN-1:0]   in_S;
    logic [W_OUT-1:0]  out_f;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;
    logic [1:0]        words;
    logic              err;
    logic [1:0]        state_dbg;

    int checks = 0;
    int errors = 0;

    // Reference model results
    logic [W_OUT-1:0]  exp_q[$];
    int                lat_q[$];
    int                exp_words;
    logic              exp_err;
    int                exp_done_lat;

    fib_chuan_split #(
        .W_IN(W_IN),
        .W_OUT(W_OUT),
        .MAX_WORDS(MAX_WORDS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .in_F(in_F),
        .in_S(in_S),
        .out_f(out_f),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy),
        .done(done),
        .words(words),
        .err(err),
        .state_dbg(state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: locate markers, cut segments, apply the frame rules.
    task automatic model(input logic [W_IN-1:0] f, input logic [W_IN-1:0] s);
        int start;
        int seg_len;
        logic [W_OUT-1:0] val;
        exp_q.delete();
        lat_q.delete();
        exp_words = 0;
        exp_err   = 1'b0;
        start     = 0;
        for (int i = 0; i < W_IN; i++) begin
            if (s[i] && exp_words < MAX_WORDS) begin
                seg_len = i - start + 1;
                val = '0;
                for (int j = 0; j < seg_len && j < W_OUT; j++) begin
                    val[j] = f[start + j];
                end
                if (seg_len > W_OUT) exp_err = 1'b1;
                if (!f[i]) exp_err = 1'b1;
                exp_q.push_back(val);
                lat_q.push_back(exp_words == 0 ? i + 2 : seg_len);
                exp_words++;
                start = i + 1;
            end
        end
        if (exp_words == MAX_WORDS) begin
            if ((s >> start) != '0) exp_err = 1'b1;
            exp_done_lat = 0;
        end else begin
            if ((f >> start) != '0) exp_err = 1'b1;
            exp_done_lat = (exp_words == 0) ? 2 : 1;
        end
    endtask

    // Driver: one frame, optional stall on the first codeword.
    task automatic run_frame(input logic [W_IN-1:0] f, input logic [W_IN-1:0] s,
                             input int stall);
        int cnt;
        int nw;
        int lat;
        logic [W_OUT-1:0] exp;
        model(f, s);
        out_ready = (stall > 0) ? 1'b0 : 1'b1;
        in_F = f;
        in_S = s;
        en   = 1'b1;
        @(posedge clk);
        #1;
        en  = 1'b0;
        cnt = 1;
        chk("busy_after_accept", busy, 1);
        nw = exp_q.size();
        for (int k = 0; k < nw; k++) begin
            exp = exp_q.pop_front();
            lat = lat_q.pop_front();
            while (!out_valid && cnt < BUDGET) begin
                @(posedge clk);
                #1;
                cnt++;
            end
            chk("out_valid", out_valid, 1);
            chk("out_f", out_f, exp);
            chk("latency", cnt, lat);
            if (k == 0 && stall > 0) begin
                repeat (stall) begin
                    @(posedge clk);
                    #1;
                    chk("stall_valid", out_valid, 1);
                    chk("stall_out_f", out_f, exp);
                end
                out_ready = 1'b1;
            end
            @(posedge clk);
            #1;
            cnt = 0;
        end
        while (!done && cnt < BUDGET) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("done", done, 1);
        chk("done_latency", cnt, exp_done_lat);
        chk("words", words, exp_words);
        chk("err", err, exp_err);
        chk("no_valid_at_done", out_valid, 0);
        @(posedge clk);
        #1;
        chk("done_one_cycle", done, 0);
        chk("busy_cleared", busy, 0);
        chk("err_sticky", err, exp_err);
    endtask

    initial begin
        logic [W_IN-1:0] f;
        logic [W_IN-1:0] s;
        int pos;
        int n;
        int seg;
        int stall;

        rst       = 1'b0;
        en        = 1'b0;
        in_F      = '0;
        in_S      = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_f", out_f, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_words", words, 0);
        chk("rst_err", err, 0);
        chk("rst_state", state_dbg, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Two codewords 1011 and 101
        run_frame(64'h5B, 64'h48, 0);
        // Same frame with a 10-cycle stall on the first codeword
        run_frame(64'h5B, 64'h48, 10);
        // Empty frame
        run_frame(64'h0, 64'h0, 0);
        // Full-width 32-bit codeword
        run_frame(64'hFFFF_FFFF, 64'h8000_0000, 0);
        // 33-bit segment: overflow
        run_frame(64'hFFFF_FFFF, 64'h1_0000_0000, 0);
        // Residual data bit without a marker, then a clean frame
        run_frame(64'h3, 64'h1, 0);
        run_frame(64'h5B, 64'h48, 0);
        // Excess marker beyond MAX_WORDS
        run_frame(64'h1D, 64'h15, 0);
        // Marker on a zero MSB
        run_frame(64'h1, 64'h2, 0);

        // Reset during SCAN discards the frame
        out_ready = 1'b1;
        in_F = 64'h5B;
        in_S = 64'h48;
        en   = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_out_f", out_f, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_words", words, 0);
        chk("midrst_err", err, 0);
        chk("midrst_state", state_dbg, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("midrst_no_done", done, 0);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_frame(64'h5B, 64'h48, 0);

        // Randomized frames
        for (int r = 0; r < 40; r++) begin
            f   = '0;
            s   = '0;
            pos = 0;
            n   = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) begin
                seg = ($urandom_range(0, 9) == 0) ? $urandom_range(30, 36)
                                                  : $urandom_range(1, 12);
                if (pos + seg <= W_IN) begin
                    for (int j = 0; j < seg - 1; j++) begin
                        f[pos + j] = 1'($urandom_range(0, 1));
                    end
                    f[pos + seg - 1] = ($urandom_range(0, 7) != 0);
                    s[pos + seg - 1] = 1'b1;
                    pos = pos + seg;
                end
            end
            if ($urandom_range(0, 4) == 0 && pos < W_IN) begin
                f[$urandom_range(pos, W_IN - 1)] = 1'b1;
            end
            stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            run_frame(f, s, stall);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
